// File: rtl/draw_pkg.sv
// Shared definitions for the grid region renderer: FSM states and default VGA widths.
package draw_pkg;

    localparam int DEF_VGA_X_BITS  = 9;
    localparam int DEF_VGA_Y_BITS  = 8;
    localparam int DEF_COLOUR_BITS = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        READ,
        FILL,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/draw_grid_region_fill_cell.sv
// Paints one CELLxCELL square: latches base position and colour on start,
// then steps a row-major pixel counter while enable is high.
module fill_cell #(
    parameter int CELL_LOG2   = 2,
    parameter int X_BITS      = 9,
    parameter int Y_BITS      = 8,
    parameter int COLOUR_BITS = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   enable,
    input  logic [X_BITS-1:0]      base_x,
    input  logic [Y_BITS-1:0]      base_y,
    input  logic [COLOUR_BITS-1:0] colour,
    output logic [X_BITS-1:0]      pix_x,
    output logic [Y_BITS-1:0]      pix_y,
    output logic [COLOUR_BITS-1:0] pix_colour,
    output logic                   pix_write,
    output logic                   last
);

    localparam int IDX_W = 2 * CELL_LOG2;

    // {py, px}: px is the low half so a plain increment gives row-major order
    logic [IDX_W-1:0]       pix_idx;
    logic [X_BITS-1:0]      base_x_r;
    logic [Y_BITS-1:0]      base_y_r;
    logic [COLOUR_BITS-1:0] colour_r;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pix_idx  <= '0;
            base_x_r <= '0;
            base_y_r <= '0;
            colour_r <= '0;
        end else if (start) begin
            pix_idx  <= '0;
            base_x_r <= base_x;
            base_y_r <= base_y;
            colour_r <= colour;
        end else if (enable) begin
            pix_idx <= pix_idx + IDX_W'(1);
        end
    end

    assign pix_x      = base_x_r + X_BITS'(pix_idx[CELL_LOG2-1:0]);
    assign pix_y      = base_y_r + Y_BITS'(pix_idx[IDX_W-1:CELL_LOG2]);
    assign pix_colour = colour_r;
    assign pix_write  = enable;
    assign last       = &pix_idx;

endmodule

// File: rtl/draw_grid_region.sv
// Region redraw engine: walks a sub-rectangle of the game grid and paints each cell.
// Optional DRAW_GRID_SKIP_BG_EN adds bg_colour and skips cells that match it.
module draw_grid_region
    import draw_pkg::*;
#(
    parameter int GRID_W      = 128,
    parameter int GRID_H      = 64,
    parameter int CELL_LOG2   = 2,
    parameter int X_OFFSET    = 0,
    parameter int Y_OFFSET    = 0,
    parameter int VGA_X_BITS  = DEF_VGA_X_BITS,
    parameter int VGA_Y_BITS  = DEF_VGA_Y_BITS,
    parameter int COLOUR_BITS = DEF_COLOUR_BITS,
    parameter int GX_BITS     = $clog2(GRID_W),
    parameter int GY_BITS     = $clog2(GRID_H)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [GX_BITS-1:0]     region_x0,
    input  logic [GX_BITS-1:0]     region_x1,
    input  logic [GY_BITS-1:0]     region_y0,
    input  logic [GY_BITS-1:0]     region_y1,
`ifdef DRAW_GRID_SKIP_BG_EN
    input  logic [COLOUR_BITS-1:0] bg_colour,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [GX_BITS-1:0]     grid_x,
    output logic [GY_BITS-1:0]     grid_y,
    input  logic [COLOUR_BITS-1:0] grid_out,
    output logic [VGA_X_BITS-1:0]  vga_x,
    output logic [VGA_Y_BITS-1:0]  vga_y,
    output logic [COLOUR_BITS-1:0] vga_colour,
    output logic                   vga_write
);

    localparam logic [GX_BITS-1:0] X_MAX = GX_BITS'(GRID_W - 1);
    localparam logic [GY_BITS-1:0] Y_MAX = GY_BITS'(GRID_H - 1);

    state_t               state, state_n;
    logic [GX_BITS-1:0]   cx, x0_r, x1_r, x1_clamp;
    logic [GY_BITS-1:0]   cy, y1_r, y1_clamp;
    logic                 empty_region, skip_cell, fill_last;
    logic                 fill_start, fill_en;
    logic [VGA_X_BITS-1:0] base_x;
    logic [VGA_Y_BITS-1:0] base_y;

    assign x1_clamp     = (region_x1 > X_MAX) ? X_MAX : region_x1;
    assign y1_clamp     = (region_y1 > Y_MAX) ? Y_MAX : region_y1;
    assign empty_region = (region_x0 > x1_clamp) || (region_y0 > y1_clamp);

`ifdef DRAW_GRID_SKIP_BG_EN
    assign skip_cell = (grid_out == bg_colour);
`else
    assign skip_cell = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cx    <= '0;
            cy    <= '0;
            x0_r  <= '0;
            x1_r  <= '0;
            y1_r  <= '0;
        end else begin
            state <= state_n;
            if (state == LOAD) begin
                x0_r <= region_x0;
                x1_r <= x1_clamp;
                y1_r <= y1_clamp;
                cx   <= region_x0;
                cy   <= region_y0;
            end else if (state == NEXT) begin
                if (cx < x1_r) begin
                    cx <= cx + GX_BITS'(1);
                end else if (cy < y1_r) begin
                    cx <= x0_r;
                    cy <= cy + GY_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    state_n = empty_region ? DONE : FETCH;
            FETCH:   state_n = READ;
            READ:    state_n = skip_cell ? NEXT : FILL;
            FILL:    if (fill_last) state_n = NEXT;
            NEXT:    state_n = ((cx < x1_r) || (cy < y1_r)) ? FETCH : DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy   = (state != IDLE) && (state != DONE);
    assign done   = (state == DONE);
    assign grid_x = cx;
    assign grid_y = cy;

    // Screen origin of the current cell, wrapping at the port widths
    assign base_x = VGA_X_BITS'(X_OFFSET) + (VGA_X_BITS'(cx) << CELL_LOG2);
    assign base_y = VGA_Y_BITS'(Y_OFFSET) + (VGA_Y_BITS'(cy) << CELL_LOG2);

    assign fill_start = (state == READ);
    assign fill_en    = (state == FILL);

    fill_cell #(
        .CELL_LOG2  (CELL_LOG2),
        .X_BITS     (VGA_X_BITS),
        .Y_BITS     (VGA_Y_BITS),
        .COLOUR_BITS(COLOUR_BITS)
    ) u_fill_cell (
        .clock     (clock),
        .reset     (reset),
        .start     (fill_start),
        .enable    (fill_en),
        .base_x    (base_x),
        .base_y    (base_y),
        .colour    (grid_out),
        .pix_x     (vga_x),
        .pix_y     (vga_y),
        .pix_colour(vga_colour),
        .pix_write (vga_write),
        .last      (fill_last)
    );

endmodule

// File: tb/tb_draw_grid_region.sv
// Directed bench for draw_grid_region: default instance plus a 130-column,
// X_OFFSET=4 instance for clamping and x wrap.
module tb_draw_grid_region;

    logic       clock = 1'b0;
    logic       reset, start, start2;
    logic [6:0] rx0, rx1;
    logic [7:0] r2x0, r2x1;
    logic [5:0] ry0, ry1;
    logic [2:0] bg_colour, fixed_colour;
    logic       use_pattern;

    logic       busy, done, vga_write;
    logic [6:0] grid_x;
    logic [5:0] grid_y;
    logic [2:0] grid_out, vga_colour;
    logic [8:0] vga_x;
    logic [7:0] vga_y;

    logic       busy2, done2, vga_write2;
    logic [7:0] grid_x2;
    logic [5:0] grid_y2;
    logic [2:0] grid_out2, vga_colour2;
    logic [8:0] vga_x2;
    logic [7:0] vga_y2;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes, first_cyc, done_cyc, busy_err, colour_err, geom_err;
    int wx[$];
    int wy[$];

    always #5 clock = ~clock;

    draw_grid_region dut (
        .clock(clock), .reset(reset), .start(start),
        .region_x0(rx0), .region_x1(rx1), .region_y0(ry0), .region_y1(ry1),
`ifdef DRAW_GRID_SKIP_BG_EN
        .bg_colour(bg_colour),
`endif
        .busy(busy), .done(done), .grid_x(grid_x), .grid_y(grid_y),
        .grid_out(grid_out), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_write(vga_write)
    );

    draw_grid_region #(.GRID_W(130), .X_OFFSET(4)) dut2 (
        .clock(clock), .reset(reset), .start(start2),
        .region_x0(r2x0), .region_x1(r2x1), .region_y0(ry0), .region_y1(ry1),
`ifdef DRAW_GRID_SKIP_BG_EN
        .bg_colour(bg_colour),
`endif
        .busy(busy2), .done(done2), .grid_x(grid_x2), .grid_y(grid_y2),
        .grid_out(grid_out2), .vga_x(vga_x2), .vga_y(vga_y2),
        .vga_colour(vga_colour2), .vga_write(vga_write2)
    );

    // Grid memory model with one cycle of read latency
    always @(posedge clock) begin
        grid_out  <= use_pattern ? (grid_x[0] ? 3'd6 : 3'd0) : fixed_colour;
        grid_out2 <= fixed_colour;
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int at_x(input int i);
        return (i < wx.size()) ? wx[i] : -1;
    endfunction

    function automatic int at_y(input int i);
        return (i < wy.size()) ? wy[i] : -1;
    endfunction

    // Start a redraw on one instance and record writes until done; cycle 0 = start accepted
    task automatic run_region(input int which, input int x0, input int x1,
                              input int y0, input int y1, input int exp_col,
                              input int budget);
        logic w, d, b;
        int   vx, vy, vc, gx, gy;
        @(negedge clock);
        rx0  = 7'(x0);
        rx1  = 7'(x1);
        r2x0 = 8'(x0);
        r2x1 = 8'(x1);
        ry0  = 6'(y0);
        ry1  = 6'(y1);
        if (which == 0) start = 1'b1;
        else            start2 = 1'b1;
        n_writes = 0; first_cyc = -1; done_cyc = -1;
        busy_err = 0; colour_err = 0; geom_err = 0;
        wx.delete();
        wy.delete();
        for (int c = 1; c <= budget && done_cyc < 0; c++) begin
            @(negedge clock);
            start  = 1'b0;
            start2 = 1'b0;
            w  = (which == 0) ? vga_write : vga_write2;
            d  = (which == 0) ? done : done2;
            b  = (which == 0) ? busy : busy2;
            vx = (which == 0) ? int'(vga_x) : int'(vga_x2);
            vy = (which == 0) ? int'(vga_y) : int'(vga_y2);
            vc = (which == 0) ? int'(vga_colour) : int'(vga_colour2);
            gx = int'(grid_x);
            gy = int'(grid_y);
            if (w) begin
                if (first_cyc < 0) first_cyc = c;
                n_writes++;
                wx.push_back(vx);
                wy.push_back(vy);
                if (vc != exp_col) colour_err++;
                if (which == 0 && (gx != (vx >> 2) || gy != (vy >> 2))) geom_err++;
            end
            if (d) begin
                done_cyc = c;
                if (b) busy_err++;
            end else if (!b) begin
                busy_err++;
            end
        end
        check("done_seen", int'(done_cyc >= 0), 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start2 = 1'b0;
        rx0 = '0; rx1 = '0; r2x0 = '0; r2x1 = '0; ry0 = '0; ry1 = '0;
        bg_colour = 3'd0; fixed_colour = 3'b101; use_pattern = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_write", vga_write, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
        check("rst_grid_x", grid_x, 0);
        reset = 1'b1;

        // Single cell at origin
        run_region(0, 0, 0, 0, 0, 5, 100);
        check("t1_writes", n_writes, 16);
        check("t1_first_cyc", first_cyc, 4);
        check("t1_done_cyc", done_cyc, 21);
        check("t1_busy", busy_err, 0);
        check("t1_colour", colour_err, 0);
        check("t1_geom", geom_err, 0);
        check("t1_first_x", at_x(0), 0);
        check("t1_first_y", at_y(0), 0);
        check("t1_px1_x", at_x(1), 1);
        check("t1_py1_y", at_y(4), 1);
        check("t1_last_x", at_x(15), 3);
        check("t1_last_y", at_y(15), 3);

        // 2x2 region, row-major cell order
        run_region(0, 2, 3, 1, 2, 5, 300);
        check("t2_writes", n_writes, 64);
        check("t2_done_cyc", done_cyc, 78);
        check("t2_geom", geom_err, 0);
        check("t2_first_x", at_x(0), 8);
        check("t2_first_y", at_y(0), 4);
        check("t2_cell2_x", at_x(16), 12);
        check("t2_cell2_y", at_y(16), 4);
        check("t2_cell3_x", at_x(32), 8);
        check("t2_cell3_y", at_y(32), 8);
        check("t2_last_x", at_x(63), 15);
        check("t2_last_y", at_y(63), 11);

        // Empty region
        run_region(0, 5, 4, 0, 0, 5, 20);
        check("t3_writes", n_writes, 0);
        check("t3_done_cyc", done_cyc, 2);

        // Rightmost column reaches the last 9-bit x
        run_region(0, 127, 127, 0, 0, 5, 100);
        check("t4_writes", n_writes, 16);
        check("t4_last_x", at_x(15), 511);

        // 130 columns, x1 clamped to 129, offset 4 wraps x
        run_region(1, 127, 200, 0, 0, 5, 200);
        check("t5_writes", n_writes, 48);
        check("t5_wrap_x", at_x(3), 3);
        check("t5_last_x", at_x(47), 11);
        check("t5_colour", colour_err, 0);

        // Reset during FILL of the second cell
        @(negedge clock);
        rx0 = 7'd0; rx1 = 7'd1; ry0 = 6'd0; ry1 = 6'd0;
        start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        check("t6_pre_write", vga_write, 1);
        check("t6_pre_grid_x", grid_x, 1);
        reset = 1'b0;
        @(negedge clock);
        check("t6_write", vga_write, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        reset = 1'b1;
        run_region(0, 0, 0, 0, 0, 5, 100);
        check("t6_again_writes", n_writes, 16);
        check("t6_again_done", done_cyc, 21);

`ifdef DRAW_GRID_SKIP_BG_EN
        // Background cell skipped, second cell painted
        use_pattern = 1'b1;
        bg_colour   = 3'd0;
        run_region(0, 0, 1, 0, 0, 6, 100);
        check("t7_writes", n_writes, 16);
        check("t7_colour", colour_err, 0);
        check("t7_first_cyc", first_cyc, 7);
        check("t7_first_x", at_x(0), 4);
        check("t7_done_cyc", done_cyc, 24);
        use_pattern = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
